// File: rtl/snn_result_tx_pkg.sv
// Shared definitions for the JTAG mailbox result link: FSM states, word width
// and header field layout used by both the transmitter and the host decoder.
package snn_link_pkg;

    typedef enum logic [1:0] {IDLE, COUNT, ARGMAX, SEND} state_t;

    localparam int          WORD_W        = 32;
    localparam logic [7:0]  MAGIC_DEFAULT = 8'hA5;
    localparam logic [7:0]  WINNER_NONE   = 8'hFF;

    // Header word layout: {magic, seq, neuron count, winner}
    localparam int HDR_MAGIC_LSB = 24;
    localparam int HDR_SEQ_LSB   = 16;
    localparam int HDR_NUM_LSB   = 8;
    localparam int HDR_WIN_LSB   = 0;

    function automatic logic [WORD_W-1:0] pack_header(input logic [7:0] magic,
                                                      input logic [7:0] seq,
                                                      input logic [7:0] num,
                                                      input logic [7:0] win);
        logic [WORD_W-1:0] h;
        h = '0;
        h[HDR_MAGIC_LSB +: 8] = magic;
        h[HDR_SEQ_LSB   +: 8] = seq;
        h[HDR_NUM_LSB   +: 8] = num;
        h[HDR_WIN_LSB   +: 8] = win;
        return h;
    endfunction

endpackage

// File: rtl/snn_result_tx_if.sv
// Result-frame word stream towards the host mailbox. A word moves on a cycle
// where oVALID and iACK are both high; while oVALID is high and iACK low the
// master holds oWORD/oLAST stable; iACK with oVALID low has no effect.
interface snn_result_tx_if;
    import snn_link_pkg::*;

    logic [WORD_W-1:0] oWORD;
    logic              oVALID;
    logic              oLAST;
    logic              iACK;

    modport master (output oWORD, output oVALID, output oLAST, input iACK);
    modport slave  (input oWORD, input oVALID, input oLAST, output iACK);

endinterface

// File: rtl/snn_result_tx_counter.sv
// One saturating spike counter: clear has priority, then increment when
// enabled and the spike bit is set, sticking at the all-ones value.
module snn_spike_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] count_o
);

    logic [CNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && inc_i && (count_q != {CNT_WIDTH{1'b1}})) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/snn_result_tx.sv
// Counts output-neuron spikes over a fixed run, picks the winner by a
// sequential scan and streams {header, counts, checksum} to the host mailbox.
module snn_result_tx
    import snn_link_pkg::*;
#(
    parameter int         NUM_NEURONS = 2,
    parameter int         CNT_WIDTH   = 16,
    parameter int         RUN_TICKS   = 64,
    parameter logic [7:0] MAGIC       = MAGIC_DEFAULT
) (
    input  logic                   iCLK,
    input  logic                   iRESET,
    input  logic                   iSTART,
    input  logic                   iSPIKE_TICK,
    input  logic [NUM_NEURONS-1:0] iNEURON_OUT,
    snn_result_tx_if.master        tx,
    output logic                   oBUSY,
    output logic                   oOVERRUN,
    output state_t                 oSTATE_DBG
);

    localparam int         IW       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int         TW       = $clog2(RUN_TICKS + 1);
    localparam logic [7:0] LAST_IDX = 8'(NUM_NEURONS + 1);

    state_t               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [IW-1:0]        scan_q, scan_d;
    logic [CNT_WIDTH-1:0] best_q, best_d;
    logic [7:0]           winner_q, winner_d;
    logic [7:0]           widx_q, widx_d;
    logic [7:0]           seq_q, seq_d;
    logic                 ovr_q, ovr_d;

    logic [CNT_WIDTH-1:0] cnt [NUM_NEURONS];
    logic [CNT_WIDTH-1:0] scan_cnt;
    logic                 start_cnt, tick_en, last_tick, xfer, last_xfer;

    // A start in IDLE or COUNT (re)opens the run; a coincident tick is dropped.
    assign start_cnt = iSTART && ((state_q == IDLE) || (state_q == COUNT));
    assign tick_en   = (state_q == COUNT) && iSPIKE_TICK && !iSTART;
    assign last_tick = tick_en && (tick_q == TW'(RUN_TICKS - 1));
    assign xfer      = (state_q == SEND) && tx.iACK;
    assign last_xfer = xfer && (widx_q == LAST_IDX);

    for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_cnt
        snn_spike_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
            .clk_i   (iCLK),
            .rst_i   (iRESET),
            .clr_i   (start_cnt),
            .en_i    (tick_en),
            .inc_i   (iNEURON_OUT[g]),
            .count_o (cnt[g])
        );
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            scan_q   <= '0;
            best_q   <= '0;
            winner_q <= WINNER_NONE;
            widx_q   <= '0;
            seq_q    <= '0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            scan_q   <= scan_d;
            best_q   <= best_d;
            winner_q <= winner_d;
            widx_q   <= widx_d;
            seq_q    <= seq_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (iSTART) state_d = COUNT;
            COUNT:   if (!iSTART && last_tick) state_d = ARGMAX;
            ARGMAX:  if (scan_q == IW'(NUM_NEURONS - 1)) state_d = SEND;
            SEND:    if (last_xfer) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tick_d   = tick_q;
        scan_d   = scan_q;
        best_d   = best_q;
        winner_d = winner_q;
        widx_d   = widx_q;
        seq_d    = seq_q;
        ovr_d    = ovr_q;
        scan_cnt = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (scan_q == IW'(i)) scan_cnt = cnt[i];
        end

        if (start_cnt) begin
            tick_d = '0;
            ovr_d  = 1'b0;
        end else if (iSTART) begin
            ovr_d  = 1'b1;
        end
        if (tick_en) tick_d = tick_q + TW'(1);
        if (last_tick) begin
            scan_d   = '0;
            best_d   = '0;
            winner_d = WINNER_NONE;
        end

        // Strict compare keeps the lowest index on ties; all-zero leaves NONE.
        if (state_q == ARGMAX) begin
            scan_d = scan_q + IW'(1);
            widx_d = '0;
            if (scan_cnt > best_q) begin
                best_d   = scan_cnt;
                winner_d = 8'(scan_q);
            end
        end

        if (xfer) widx_d = widx_q + 8'd1;
        if (last_xfer) seq_d = seq_q + 8'd1;
    end

    always_comb begin
        logic [WORD_W-1:0] hdr, chk;
        hdr = pack_header(MAGIC, seq_q, 8'(NUM_NEURONS), winner_q);
        chk = hdr;
        for (int i = 0; i < NUM_NEURONS; i++) chk = chk ^ WORD_W'(cnt[i]);

        tx.oWORD  = '0;
        tx.oVALID = 1'b0;
        tx.oLAST  = 1'b0;
        if (state_q == SEND) begin
            tx.oVALID = 1'b1;
            if (widx_q == 8'd0) begin
                tx.oWORD = hdr;
            end else if (widx_q == LAST_IDX) begin
                tx.oWORD = chk;
                tx.oLAST = 1'b1;
            end else begin
                for (int i = 0; i < NUM_NEURONS; i++) begin
                    if (widx_q == 8'(i + 1)) tx.oWORD = WORD_W'(cnt[i]);
                end
            end
        end
        oBUSY      = (state_q != IDLE);
        oOVERRUN   = ovr_q;
        oSTATE_DBG = state_q;
    end

endmodule

// File: tb/tb_snn_result_tx.sv
// Directed bench for snn_result_tx: one 16-bit/4-tick instance and one
// 2-bit/6-tick instance for counter saturation.
module tb_snn_result_tx;
    import snn_link_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, start_a, tick_a, busy_a, ovr_a;
    logic       rst_b, start_b, tick_b, busy_b, ovr_b;
    logic [1:0] nout_a, nout_b;
    state_t     st_a, st_b;

    snn_result_tx_if if_a ();
    snn_result_tx_if if_b ();

    snn_result_tx #(.NUM_NEURONS(2), .CNT_WIDTH(16), .RUN_TICKS(4)) dut_a (
        .iCLK(clk), .iRESET(rst_a), .iSTART(start_a), .iSPIKE_TICK(tick_a),
        .iNEURON_OUT(nout_a), .tx(if_a), .oBUSY(busy_a), .oOVERRUN(ovr_a),
        .oSTATE_DBG(st_a)
    );

    snn_result_tx #(.NUM_NEURONS(2), .CNT_WIDTH(2), .RUN_TICKS(6)) dut_b (
        .iCLK(clk), .iRESET(rst_b), .iSTART(start_b), .iSPIKE_TICK(tick_b),
        .iNEURON_OUT(nout_b), .tx(if_b), .oBUSY(busy_b), .oOVERRUN(ovr_b),
        .oSTATE_DBG(st_b)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] got_w [8];
    int          got_n;
    int          got_last;
    bit          got_timeout;
    logic [31:0] exp_q [$];

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic cycle(input bit sel, input bit s, input bit t, input logic [1:0] v);
        if (sel) begin start_b = s; tick_b = t; nout_b = v; end
        else     begin start_a = s; tick_a = t; nout_a = v; end
        @(negedge clk);
        start_a = 1'b0; tick_a = 1'b0; nout_a = 2'b00;
        start_b = 1'b0; tick_b = 1'b0; nout_b = 2'b00;
    endtask

    task automatic do_reset(input bit sel);
        if (sel) rst_b = 1'b1; else rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
    endtask

    task automatic run_ticks(input bit sel, input int n, input logic [15:0] vecs);
        logic [15:0] tmp;
        for (int i = 0; i < n; i++) begin
            tmp = vecs >> (2 * i);
            cycle(sel, 1'b0, 1'b1, tmp[1:0]);
        end
    endtask

    task automatic start_frame(input bit sel, input int n, input logic [15:0] vecs);
        cycle(sel, 1'b1, 1'b0, 2'b00);
        run_ticks(sel, n, vecs);
    endtask

    task automatic wait_valid(input bit sel, output bit to);
        to = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (sel ? if_b.oVALID : if_a.oVALID) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Acks every word until the one flagged last has been transferred.
    task automatic collect(input bit sel);
        got_n = 0;
        got_last = -1;
        if (sel) if_b.iACK = 1'b1; else if_a.iACK = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (sel ? if_b.oVALID : if_a.oVALID) begin
                if (got_n < 8) got_w[got_n] = sel ? if_b.oWORD : if_a.oWORD;
                if ((sel ? if_b.oLAST : if_a.oLAST) && got_last < 0) got_last = got_n;
                got_n++;
            end
            @(negedge clk);
            if (got_last >= 0) break;
        end
        got_timeout = (got_last < 0);
        if_a.iACK = 1'b0;
        if_b.iACK = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        n_checks++;
        if ({if_a.oVALID, if_a.oLAST, busy_a, ovr_a} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags_a: got %b want 0000", {if_a.oVALID, if_a.oLAST, busy_a, ovr_a});
        end
        n_checks++;
        if (if_a.oWORD !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_word_a: got %h want 00000000", if_a.oWORD);
        end
        n_checks++;
        if ({if_b.oVALID, if_b.oLAST, busy_b, ovr_b} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags_b: got %b want 0000", {if_b.oVALID, if_b.oLAST, busy_b, ovr_b});
        end
    endtask

    task automatic test_basic();
        do_reset(1'b0);
        cycle(1'b0, 1'b1, 1'b0, 2'b00);
        n_checks++;
        if (busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy_count: got %b want 1", busy_a);
        end
        run_ticks(1'b0, 4, 16'h0035);
        collect(1'b0);
        exp_q = '{32'hA5000200, 32'h3, 32'h1, 32'hA5000202};
        n_checks++;
        if (got_timeout || got_n !== 4 || got_last !== 3) begin
            n_fail++;
            $display("FAIL basic_len: got n=%0d last=%0d to=%0d want n=4 last=3 to=0", got_n, got_last, got_timeout);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got_w[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL basic_word%0d: got %h want %h", i, got_w[i], exp_q[i]);
            end
        end
        n_checks++;
        if ({if_a.oVALID, busy_a} !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_after: valid/busy got %b want 00", {if_a.oVALID, busy_a});
        end
    endtask

    task automatic test_tie_nospike();
        do_reset(1'b0);
        start_frame(1'b0, 4, 16'h000F);
        collect(1'b0);
        exp_q = '{32'hA5000200, 32'h2, 32'h2, 32'hA5000200};
        n_checks++;
        if (got_timeout || got_n !== 4) begin
            n_fail++;
            $display("FAIL tie_len: got n=%0d to=%0d want n=4 to=0", got_n, got_timeout);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got_w[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL tie_word%0d: got %h want %h", i, got_w[i], exp_q[i]);
            end
        end
        start_frame(1'b0, 4, 16'h0000);
        collect(1'b0);
        exp_q = '{32'hA50102FF, 32'h0, 32'h0, 32'hA50102FF};
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got_w[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL nospike_word%0d: got %h want %h", i, got_w[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit to;
        do_reset(1'b0);
        start_frame(1'b0, 4, 16'h0035);
        wait_valid(1'b0, to);
        n_checks++;
        if (to || if_a.oWORD !== 32'hA5000200) begin
            n_fail++;
            $display("FAIL bp_word0: got %h to=%0d want a5000200", if_a.oWORD, to);
        end
        if_a.iACK = 1'b1;
        @(negedge clk);
        if_a.iACK = 1'b0;
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if ({if_a.oVALID, if_a.oLAST, if_a.oWORD} !== {2'b10, 32'h3}) begin
                n_fail++;
                $display("FAIL bp_hold%0d: got v=%b l=%b w=%h want v=1 l=0 w=3", c, if_a.oVALID, if_a.oLAST, if_a.oWORD);
            end
            @(negedge clk);
        end
        if_a.iACK = 1'b1;
        exp_q = '{32'h3, 32'h1, 32'hA5000202};
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (if_a.oVALID !== 1'b1 || if_a.oWORD !== exp_q[i] || if_a.oLAST !== (i == 2)) begin
                n_fail++;
                $display("FAIL bp_word%0d: got v=%b w=%h l=%b want w=%h", i + 1, if_a.oVALID, if_a.oWORD, if_a.oLAST, exp_q[i]);
            end
            @(negedge clk);
        end
        if_a.iACK = 1'b0;
        n_checks++;
        if (if_a.oVALID !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_end_valid: got %b want 0", if_a.oVALID);
        end
    endtask

    task automatic test_saturation();
        do_reset(1'b1);
        start_frame(1'b1, 6, 16'h0555);
        collect(1'b1);
        exp_q = '{32'hA5000200, 32'h3, 32'h0, 32'hA5000203};
        n_checks++;
        if (got_timeout || got_n !== 4) begin
            n_fail++;
            $display("FAIL sat_len: got n=%0d to=%0d want n=4 to=0", got_n, got_timeout);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got_w[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL sat_word%0d: got %h want %h", i, got_w[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_restart_overrun();
        bit to;
        do_reset(1'b0);
        start_frame(1'b0, 2, 16'h000F);
        cycle(1'b0, 1'b1, 1'b1, 2'b11);
        run_ticks(1'b0, 4, 16'h0035);
        wait_valid(1'b0, to);
        n_checks++;
        if (to || ovr_a !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_before: got %b to=%0d want 0", ovr_a, to);
        end
        cycle(1'b0, 1'b1, 1'b0, 2'b00);
        n_checks++;
        if (ovr_a !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_set: got %b want 1", ovr_a);
        end
        collect(1'b0);
        exp_q = '{32'hA5000200, 32'h3, 32'h1, 32'hA5000202};
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got_w[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL restart_word%0d: got %h want %h", i, got_w[i], exp_q[i]);
            end
        end
        n_checks++;
        if (ovr_a !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_sticky: got %b want 1", ovr_a);
        end
        cycle(1'b0, 1'b1, 1'b0, 2'b00);
        n_checks++;
        if ({ovr_a, busy_a} !== 2'b01) begin
            n_fail++;
            $display("FAIL ovr_clear: ovr/busy got %b want 01", {ovr_a, busy_a});
        end
    endtask

    task automatic test_reset_mid_send();
        bit to;
        do_reset(1'b0);
        start_frame(1'b0, 4, 16'h0035);
        collect(1'b0);
        start_frame(1'b0, 4, 16'h0035);
        wait_valid(1'b0, to);
        if_a.iACK = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if_a.iACK = 1'b0;
        n_checks++;
        if (to || if_a.oWORD !== 32'h1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got %h to=%0d want 00000001", if_a.oWORD, to);
        end
        do_reset(1'b0);
        n_checks++;
        if ({if_a.oVALID, busy_a, if_a.oWORD} !== {2'b00, 32'h0}) begin
            n_fail++;
            $display("FAIL rst_mid_out: got v=%b b=%b w=%h want 0 0 0", if_a.oVALID, busy_a, if_a.oWORD);
        end
        start_frame(1'b0, 4, 16'h0035);
        collect(1'b0);
        n_checks++;
        if (got_timeout || got_w[0] !== 32'hA5000200) begin
            n_fail++;
            $display("FAIL rst_mid_seq: got %h to=%0d want a5000200", got_w[0], got_timeout);
        end
    endtask

    initial begin
        rst_a = 1'b0; start_a = 1'b0; tick_a = 1'b0; nout_a = 2'b00;
        rst_b = 1'b0; start_b = 1'b0; tick_b = 1'b0; nout_b = 2'b00;
        if_a.iACK = 1'b0;
        if_b.iACK = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_tie_nospike();
        test_backpressure();
        test_saturation();
        test_restart_overrun();
        test_reset_mid_send();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/snn_result_tx.md
Name: snn_result_tx

Overview:
- Transmit end of the JTAG mailbox link; the image loader is the receive end.
- Accumulates per-output-neuron spike counts from run_network over a fixed number of spike-clock steps.
- Selects the winning neuron.
- Streams a fixed-format result frame of 32-bit words to the host-side mailbox using a valid/ack handshake.
- Sits between run_network.neuron_out and the MyDesign OUT_* register path.

Parameters:
- NUM_NEURONS, 2, number of output neurons; must be 1..254.
- CNT_WIDTH, 16, spike counter width; must be ≤ 32, zero-extended into words.
- RUN_TICKS, 64, spike steps counted per inference; must be ≥ 1.
- MAGIC, 8'hA5, header tag byte.

Ports:
- iCLK, in, 1: system clock (wCLK8 domain).
- iRESET, in, 1: synchronous, active-high reset.
- iSTART, in, 1: one-cycle pulse; a new inference begins.
- iSPIKE_TICK, in, 1: one-cycle strobe per spike-clock step.
- iNEURON_OUT, in, NUM_NEURONS: spike vector, sampled only when iSPIKE_TICK=1.
- oWORD, out, 32: current frame word.
- oVALID, out, 1: oWORD valid.
- iACK, in, 1: host consumed oWORD; a transfer occurs when oVALID&iACK.
- oLAST, out, 1: oWORD is the final (checksum) word.
- oBUSY, out, 1: high in every state except IDLE.
- oOVERRUN, out, 1: sticky; iSTART arrived while in ARGMAX or SEND.

Behaviour:
- Reset (synchronous, iRESET=1 at posedge):
  - State←IDLE; all counters, tick count and seq←0.
  - oWORD=0, oVALID=0, oLAST=0, oBUSY=0, oOVERRUN=0.
  - Reset asserted mid-frame drops oVALID the next cycle; the partial frame is abandoned.
- IDLE:
  - iSTART → COUNT.
  - Entering COUNT clears counts and tick count, and clears oOVERRUN.
- COUNT:
  - On iSPIKE_TICK: for each i, count[i]+=iNEURON_OUT[i], saturating at 2^CNT_WIDTH-1; tick count+1.
  - When tick count reaches RUN_TICKS (the tick that makes it equal is included) → ARGMAX.
  - iSTART in COUNT restarts: counts and ticks cleared; seq unchanged.
  - iSTART and iSPIKE_TICK in the same cycle: start wins; the tick is ignored.
- ARGMAX:
  - Sequential scan, one neuron per cycle: exactly NUM_NEURONS cycles, then → SEND.
  - Ties resolve to the lowest index.
  - If all counts are 0, winner=8'hFF.
- SEND:
  - Frame length = NUM_NEURONS+2 words.
  - Word 0: {MAGIC, seq[7:0], NUM_NEURONS[7:0], winner[7:0]}.
  - Words 1..N: count[i-1], zero-extended.
  - Final word: XOR of all preceding words; oLAST=1 on it.
  - oVALID rises on the first SEND cycle.
  - oWORD and oLAST are held stable while oVALID&!iACK, for any duration.
  - After a transfer, the next word is presented the following cycle; oVALID stays high with no bubble.
  - iACK while oVALID=0 is ignored.
  - Transfer of the final word → oVALID=0, seq+1 (wraps 255→0), → IDLE.
- iSTART during ARGMAX or SEND: ignored; oOVERRUN←1.
- iSPIKE_TICK outside COUNT: ignored.
- Reset is the only abort of a frame in progress.

Decomposition:
- Package snn_link_pkg holds:
  - state enum {IDLE, COUNT, ARGMAX, SEND};
  - MAGIC default;
  - WORD_W=32;
  - WINNER_NONE=8'hFF;
  - header field bit positions (shared with the image loader's frame decoder on the host side).
- One natural sub-module, snn_spike_counter: a single saturating counter with clear and enable; instantiated NUM_NEURONS times via generate.
- The FSM, argmax and serializer stay in snn_result_tx.

Test Plan:
1. Basic frame, NUM_NEURONS=2, RUN_TICKS=4.
   - Stimulus: iSTART; ticks with iNEURON_OUT=01,01,11,00; iACK held 1.
   - Required: words 32'hA5000200, 3, 1, 32'hA5000202 with oLAST on the last word; oVALID high exactly 4 cycles; seq→1.
2. Tie and no-spike frames.
   - Stimulus: tick vectors 11,11,00,00.
   - Required: winner byte 00; counts 2,2.
   - Stimulus: next frame all 00.
   - Required: header 32'hA50102FF; checksum 32'hA50102FF.
3. Backpressure.
   - Stimulus: iACK=0 for 10 cycles on word 1, then 1.
   - Required: oWORD=3 stable all 10 cycles; total frame still 4 transfers; no duplicated or skipped words.
4. Saturation, CNT_WIDTH=2, RUN_TICKS=6.
   - Stimulus: iNEURON_OUT=01 on every tick.
   - Required: word1=3, word2=0; winner 0.
5. Restart and overrun.
   - Stimulus: iSTART after 2 ticks in COUNT.
   - Required: counts restart from 0; frame reflects only the post-restart 4 ticks.
   - Stimulus: iSTART during SEND.
   - Required: oOVERRUN=1 and frame unaffected; the next accepted iSTART clears oOVERRUN.
6. Reset mid-SEND.
   - Stimulus: iRESET for 1 cycle after word 1 is transferred.
   - Required: oVALID=0, oBUSY=0 next cycle; the next frame header carries seq 0.
